// File: rtl/multi_pulse_pkg.sv
// Shared definitions for the multi-channel pulse generator.
package multi_pulse_pkg;

  // Edge-select encodings, common to all channels.
  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  // Per-channel pulse state.
  typedef enum logic {
    StIdle,
    StActive
  } chan_state_e;

  // Selects which synchronised edges count as a trigger.
  function automatic logic edge_sel(logic [1:0] mode, logic rise, logic fall);
    logic sel;
    case (mode)
      MODE_RISE: sel = rise;
      MODE_FALL: sel = fall;
      MODE_BOTH: sel = rise | fall;
      MODE_OFF:  sel = 1'b0;
      default:   sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multi_pulse_gen_if.sv
// Control/status bundle between the pulse generator and its user.
interface multi_pulse_gen_if #(
  parameter int unsigned CH    = 4,
  parameter int unsigned CNT_W = 8
);
  logic [CH-1:0]    load;
  logic [1:0]       mode;
  logic [CNT_W-1:0] width;
  logic             retrig;
  logic [CH-1:0]    miss_clr;
  logic [CH-1:0]    q;
  logic [CH-1:0]    busy;
  logic [CH-1:0]    miss;

  modport master (
    output load, mode, width, retrig, miss_clr,
    input  q, busy, miss
  );

  modport slave (
    input  load, mode, width, retrig, miss_clr,
    output q, busy, miss
  );
endinterface

// File: rtl/pulse_chan.sv
// One channel: synchroniser, edge detector, pulse-length counter and sticky miss flag.
module pulse_chan
  import multi_pulse_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic             retrig_i,
  input  logic             miss_clr_i,
  output logic             q_o,
  output logic             miss_o
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  chan_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   miss_q, miss_d;

  logic             sync_s;
  logic             edge_det;
  logic [CNT_W-1:0] width_eff;

  assign sync_s    = sync_q[SYNC_STAGES-1];
  assign edge_det  = edge_sel(mode_i, sync_s & ~hist_q, ~sync_s & hist_q);
  // A programmed width of zero still yields a one-cycle pulse.
  assign width_eff = (width_i == '0) ? CntOne : width_i;

  // Synchroniser, edge history and pulse state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
      miss_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], load_i};
      hist_q  <= sync_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
    end
  end

  // Next-state: trigger, count down, retrigger or record a dropped edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q & ~miss_clr_i;
    unique case (state_q)
      StIdle: begin
        if (edge_det) begin
          state_d = StActive;
          cnt_d   = width_eff;
        end
      end
      StActive: begin
        if (edge_det && retrig_i) begin
          cnt_d = width_eff;
        end else begin
          // A new miss overrides a simultaneous clear.
          if (edge_det) begin
            miss_d = 1'b1;
          end
          if (cnt_q == CntOne) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
      end
    endcase
  end

  assign q_o    = (state_q == StActive);
  assign miss_o = miss_q;

endmodule

// File: rtl/multi_pulse_gen.sv
// Multi-channel edge-triggered pulse generator; shared controls fan out to every channel.
module multi_pulse_gen
  import multi_pulse_pkg::*;
#(
  parameter int unsigned CH          = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  multi_pulse_gen_if.slave bus
);

  logic [CH-1:0] q_w;
  logic [CH-1:0] miss_w;

  for (genvar i = 0; i < CH; i++) begin : g_chan
    pulse_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .load_i     (bus.load[i]),
      .mode_i     (bus.mode),
      .width_i    (bus.width),
      .retrig_i   (bus.retrig),
      .miss_clr_i (bus.miss_clr[i]),
      .q_o        (q_w[i]),
      .miss_o     (miss_w[i])
    );
  end

  assign bus.q    = q_w;
  assign bus.busy = q_w;
  assign bus.miss = miss_w;

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Directed bench for multi_pulse_gen: vector table plus multi-cycle corner sequences.
module tb_multi_pulse_gen;

  logic clk = 1'b0;
  logic rst;

  multi_pulse_gen_if #(.CH(4), .CNT_W(8)) bus ();

  multi_pulse_gen #(
    .CH          (4),
    .CNT_W       (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One level change on a channel, then watch its q for a window.
  typedef struct {
    int         ch;
    logic [1:0] mode;
    logic [7:0] width;
    logic       lvl;
    int         exp_delay;  // clk edges from first sampling edge to q rising, -1 if none
    int         exp_len;
  } vec_t;

  vec_t vecs[11];

  // Toggle load[ch]; once q is seen high optionally toggle again (second edge lands
  // in the third pulse cycle) and optionally pulse miss_clr in that same cycle.
  task automatic pulse_seq(input int ch, input bit second, input bit clr, output int len);
    bit seen;
    @(negedge clk);
    bus.load[ch] = ~bus.load[ch];
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (bus.q[ch]) seen = 1'b1;
    end
    len = 0;
    if (!seen) return;
    len = 1;
    if (second) bus.load[ch] = ~bus.load[ch];
    for (int j = 1; j < 300; j++) begin
      @(negedge clk);
      bus.miss_clr[ch] = clr && (j == 2);
      if (bus.q[ch]) len++;
      else break;
    end
    bus.miss_clr = '0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int delay, len, win, cnt;
    bit  found;
    logic [3:0] qv, bv;

    vecs[0]  = '{0, 2'b00, 8'd1,   1'b1,  2, 1};
    vecs[1]  = '{1, 2'b00, 8'd5,   1'b1,  2, 5};
    vecs[2]  = '{1, 2'b00, 8'd5,   1'b0, -1, 0};
    vecs[3]  = '{1, 2'b01, 8'd5,   1'b1, -1, 0};
    vecs[4]  = '{1, 2'b01, 8'd5,   1'b0,  2, 5};
    vecs[5]  = '{2, 2'b10, 8'd3,   1'b1,  2, 3};
    vecs[6]  = '{2, 2'b10, 8'd3,   1'b0,  2, 3};
    vecs[7]  = '{2, 2'b11, 8'd3,   1'b1, -1, 0};
    vecs[8]  = '{2, 2'b11, 8'd3,   1'b0, -1, 0};
    vecs[9]  = '{3, 2'b00, 8'd0,   1'b1,  2, 1};
    vecs[10] = '{3, 2'b10, 8'd200, 1'b0,  2, 200};

    rst          = 1'b1;
    bus.load     = '0;
    bus.mode     = 2'b00;
    bus.width    = 8'd1;
    bus.retrig   = 1'b0;
    bus.miss_clr = '0;
    repeat (2) @(negedge clk);
    check("reset q", int'(bus.q), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset miss", int'(bus.miss), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven single edges.
    foreach (vecs[i]) begin
      @(negedge clk);
      bus.mode   = vecs[i].mode;
      bus.width  = vecs[i].width;
      bus.retrig = 1'b0;
      bus.load[vecs[i].ch] = vecs[i].lvl;
      win   = int'(vecs[i].width) + 20;
      delay = -1;
      len   = 0;
      for (int j = 1; j <= win; j++) begin
        @(negedge clk);
        if (bus.q[vecs[i].ch]) begin
          if (delay < 0) delay = j - 1;
          len++;
        end
      end
      check($sformatf("vec%0d delay", i), delay, vecs[i].exp_delay);
      check($sformatf("vec%0d length", i), len, vecs[i].exp_len);
      check($sformatf("vec%0d miss", i), int'(bus.miss[vecs[i].ch]), 0);
    end

    // Second edge while active, no retrigger: pulse unchanged, miss set.
    bus.mode   = 2'b10;
    bus.width  = 8'd6;
    bus.retrig = 1'b0;
    pulse_seq(0, 1'b1, 1'b0, len);
    check("noretrig length", len, 6);
    check("noretrig miss", int'(bus.miss[0]), 1);

    @(negedge clk);
    bus.miss_clr[0] = 1'b1;
    @(negedge clk);
    bus.miss_clr[0] = 1'b0;
    check("miss cleared", int'(bus.miss[0]), 0);

    // Retrigger three cycles in: 3 + 6 contiguous cycles.
    repeat (3) @(negedge clk);
    bus.retrig = 1'b1;
    pulse_seq(0, 1'b1, 1'b0, len);
    check("retrig length", len, 9);
    check("retrig miss", int'(bus.miss[0]), 0);

    // New miss coinciding with miss_clr: the set must win.
    repeat (3) @(negedge clk);
    bus.retrig = 1'b0;
    pulse_seq(0, 1'b1, 1'b1, len);
    check("setclr length", len, 6);
    check("setclr miss", int'(bus.miss[0]), 1);

    // Reset in the middle of a long pulse.
    @(negedge clk);
    bus.mode  = 2'b00;
    bus.width = 8'd20;
    bus.load  = '0;
    repeat (5) @(negedge clk);
    bus.load[1] = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk);
      if (bus.q[1]) found = 1'b1;
    end
    check("rst pulse started", int'(found), 1);
    repeat (3) @(negedge clk);
    rst         = 1'b1;
    bus.load[1] = 1'b0;
    @(negedge clk);
    check("rst mid q", int'(bus.q), 0);
    check("rst mid busy", int'(bus.busy), 0);
    rst = 1'b0;
    cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.q != '0) cnt++;
    end
    check("no resume after rst", cnt, 0);

    // Load held high through reset yields one rise after release.
    rst         = 1'b1;
    bus.load[2] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.q[2]) cnt++;
    end
    check("held through rst", cnt, 20);
    bus.load[2] = 1'b0;
    repeat (5) @(negedge clk);

    // All channels trigger on the same cycle.
    bus.width = 8'd4;
    bus.load  = 4'hF;
    qv = '0;
    bv = '0;
    for (int n = 0; n < 10 && qv == '0; n++) begin
      @(negedge clk);
      qv = bus.q;
      bv = bus.busy;
    end
    check("all ch q", int'(qv), 15);
    check("all ch busy", int'(bv), 15);
    len = 1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.q == 4'hF) len++;
      else break;
    end
    check("all ch length", len, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
